// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RISC-V M-extension unit.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational decode of an M-extension instruction: class, result half and operand signedness.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic       r_type_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic       is_muldiv_o,
  output logic       is_div_o,
  output logic       is_high_o,
  output logic       is_rem_o,
  output logic       a_signed_o,
  output logic       b_signed_o
);

  always_comb begin
    is_muldiv_o = (alu_op_i == 2'b10) && r_type_i && (funct7_i == FUNCT7_MULDIV);
    is_div_o    = funct3_i[2];
    is_high_o   = 1'b0;
    is_rem_o    = 1'b0;
    a_signed_o  = 1'b0;
    b_signed_o  = 1'b0;
    unique case (funct3_i)
      F3_MUL:    ;
      F3_MULH:   begin is_high_o = 1'b1; a_signed_o = 1'b1; b_signed_o = 1'b1; end
      F3_MULHSU: begin is_high_o = 1'b1; a_signed_o = 1'b1; end
      F3_MULHU:  is_high_o = 1'b1;
      F3_DIV:    begin a_signed_o = 1'b1; b_signed_o = 1'b1; end
      F3_DIVU:   ;
      F3_REM:    begin is_rem_o = 1'b1; a_signed_o = 1'b1; b_signed_o = 1'b1; end
      F3_REMU:   is_rem_o = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes, sign fix at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic             RType,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             Valid,
  input  logic             Flush,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             IsMulDiv,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic dec_div, dec_high, dec_rem, dec_a_signed, dec_b_signed;

  muldiv_decode u_decode (
    .alu_op_i    (ALUOp),
    .r_type_i    (RType),
    .funct7_i    (Funct7),
    .funct3_i    (Funct3),
    .is_muldiv_o (IsMulDiv),
    .is_div_o    (dec_div),
    .is_high_o   (dec_high),
    .is_rem_o    (dec_rem),
    .a_signed_o  (dec_a_signed),
    .b_signed_o  (dec_b_signed)
  );

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;    // mul: product high half; div: partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;    // mul: multiplier/product low; div: dividend/quotient
  logic [WIDTH-1:0] opd_q, opd_d;  // multiplicand or divisor magnitude
  logic             high_q, high_d, rem_q, rem_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, special_q, special_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept, last;
  logic             a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    accept   = (state_q == IDLE) && Valid && IsMulDiv && !Flush;
    last     = (cnt_q == CW'(WIDTH - 1));
    a_neg    = dec_a_signed & SrcA[WIDTH-1];
    b_neg    = dec_b_signed & SrcB[WIDTH-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag    = b_neg ? -SrcB : SrcB;
    div_zero = (SrcB == '0);
    div_ovf  = dec_b_signed && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
  end

  // One iteration of each datapath plus its sign-corrected final value.
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo, quo, rem, mul_res, div_res;
  logic [2*WIDTH-1:0] prod, prod_c;
  logic               div_ok;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opd_q : {WIDTH{1'b0}})};
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    prod      = {mul_hi, mul_lo};
    prod_c    = neg_q ? -prod : prod;
    mul_res   = high_q ? prod_c[2*WIDTH-1:WIDTH] : prod_c[WIDTH-1:0];

    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opd_q};
    div_ok    = !div_trial[WIDTH];
    div_hi    = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ok};
    quo       = neg_q ? -div_lo : div_lo;
    rem       = rneg_q ? -div_hi : div_hi;
    div_res   = rem_q ? rem : quo;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opd_d     = opd_q;
    high_d    = high_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    special_d = special_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          hi_d      = '0;
          high_d    = dec_high;
          rem_d     = dec_rem;
          neg_d     = a_neg ^ b_neg;
          rneg_d    = a_neg;
          special_d = 1'b0;
          if (dec_div) begin
            state_d = DIV;
            lo_d    = a_mag;
            opd_d   = b_mag;
            // Special cases park their final answer in lo and finish next edge.
            if (div_zero) begin
              special_d = 1'b1;
              lo_d      = dec_rem ? SrcA : '1;
            end else if (div_ovf) begin
              special_d = 1'b1;
              lo_d      = dec_rem ? '0 : SrcA;
            end
          end else begin
            state_d = MUL;
            lo_d    = b_mag;
            opd_d   = a_mag;
          end
        end
      end
      MUL: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          hi_d  = mul_hi;
          lo_d  = mul_lo;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d  = DONE;
            result_d = mul_res;
          end
        end
      end
      DIV: begin
        if (Flush) begin
          state_d = IDLE;
        end else if (special_q) begin
          state_d  = DONE;
          result_d = lo_q;
        end else begin
          hi_d  = div_hi;
          lo_d  = div_lo;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d  = DONE;
            result_d = div_res;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      high_q    <= 1'b0;
      rem_q     <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opd_q     <= opd_d;
      high_q    <= high_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign Stall  = accept || (state_q == MUL) || (state_q == DIV);
  assign Done   = (state_q == DONE);
  assign Result = result_q;

endmodule
